// File: rtl/writeback_forward_pkg.sv
// Shared widths, the zero-register index and the operand source selector
// for the writeback/forwarding slice.
package writeback_forward_pkg;

    localparam int unsigned DATA_LENGTH = 64;
    localparam int unsigned ADDRESS     = 5;
    localparam int unsigned XZR         = 31;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_MEM,
        FWD_WB
    } fwd_sel_t;

endpackage

// File: rtl/writeback_forward_fwd_select.sv
// Per-operand hazard resolution: MEM result beats WB result beats the
// regfile read, and the zero register always reads as 0.
module fwd_select
    import writeback_forward_pkg::*;
#(
    parameter int unsigned DATA_LENGTH = writeback_forward_pkg::DATA_LENGTH,
    parameter int unsigned ADDRESS     = writeback_forward_pkg::ADDRESS
) (
    input  logic [ADDRESS-1:0]     src_i,
    input  logic [DATA_LENGTH-1:0] rf_data_i,
    input  logic                   mem_wr_i,
    input  logic [ADDRESS-1:0]     mem_rd_i,
    input  logic [DATA_LENGTH-1:0] mem_val_i,
    input  logic                   wb_wr_i,
    input  logic [ADDRESS-1:0]     wb_rd_i,
    input  logic [DATA_LENGTH-1:0] wb_val_i,
    output logic [DATA_LENGTH-1:0] operand_o
);

    localparam logic [ADDRESS-1:0] ZR = ADDRESS'(XZR);

    fwd_sel_t sel_d;
    logic     src_zr;

    assign src_zr = (src_i == ZR);

    always_comb begin
        sel_d = FWD_RF;
        if (mem_wr_i && (mem_rd_i == src_i) && !src_zr) begin
            sel_d = FWD_MEM;
        end else if (wb_wr_i && (wb_rd_i == src_i) && !src_zr) begin
            sel_d = FWD_WB;
        end
    end

    always_comb begin
        operand_o = rf_data_i;
        case (sel_d)
            FWD_MEM: operand_o = mem_val_i;
            FWD_WB:  operand_o = wb_val_i;
            default: operand_o = rf_data_i;
        endcase
        if (src_zr) begin
            operand_o = '0;
        end
    end

endmodule

// File: rtl/writeback_forward.sv
// EX->MEM and MEM->WB pipeline registers, regfile write port, load-use stall
// and operand forwarding for the ID stage.
module writeback_forward
    import writeback_forward_pkg::*;
#(
    parameter int unsigned DATA_LENGTH = writeback_forward_pkg::DATA_LENGTH,
    parameter int unsigned ADDRESS     = writeback_forward_pkg::ADDRESS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ExRegWrite,
    input  logic                   ExMemRead,
    input  logic [ADDRESS-1:0]     ExRd,
    input  logic [DATA_LENGTH-1:0] ExResult,
    input  logic [DATA_LENGTH-1:0] MemData,
    input  logic [ADDRESS-1:0]     IdRn,
    input  logic [ADDRESS-1:0]     IdRm,
    input  logic [DATA_LENGTH-1:0] ReadData1,
    input  logic [DATA_LENGTH-1:0] ReadData2,
    output logic [DATA_LENGTH-1:0] Operand1,
    output logic [DATA_LENGTH-1:0] Operand2,
    output logic                   Stall,
    output logic [ADDRESS-1:0]     WriteRegister,
    output logic [DATA_LENGTH-1:0] WriteData,
    output logic                   RegWrite
);

    localparam logic [ADDRESS-1:0] ZR = ADDRESS'(XZR);

    logic                   mem_regwrite_q;
    logic                   mem_memread_q;
    logic [ADDRESS-1:0]     mem_rd_q;
    logic [DATA_LENGTH-1:0] mem_result_q;
    logic [DATA_LENGTH-1:0] mem_value_d;

    logic                   wb_regwrite_q;
    logic [ADDRESS-1:0]     wb_rd_q;
    logic [DATA_LENGTH-1:0] wb_value_q;

    assign mem_value_d = mem_memread_q ? MemData : mem_result_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_regwrite_q <= 1'b0;
            mem_memread_q  <= 1'b0;
            mem_rd_q       <= ZR;
            mem_result_q   <= '0;
            wb_regwrite_q  <= 1'b0;
            wb_rd_q        <= ZR;
            wb_value_q     <= '0;
        end else begin
            mem_regwrite_q <= ExRegWrite;
            mem_memread_q  <= ExMemRead;
            mem_rd_q       <= ExRd;
            mem_result_q   <= ExResult;
            wb_regwrite_q  <= mem_regwrite_q;
            wb_rd_q        <= mem_rd_q;
            wb_value_q     <= mem_value_d;
        end
    end

    // The write enable is masked by reset so the instruction sitting in WB at
    // the reset edge does not commit; address/data stay straight from the register.
    assign RegWrite      = wb_regwrite_q & ~reset;
    assign WriteRegister = wb_rd_q;
    assign WriteData     = wb_value_q;

    assign Stall = ExRegWrite & ExMemRead & (ExRd != ZR) &
                   ((ExRd == IdRn) | (ExRd == IdRm));

    fwd_select #(
        .DATA_LENGTH(DATA_LENGTH),
        .ADDRESS    (ADDRESS)
    ) u_fwd_rn (
        .src_i    (IdRn),
        .rf_data_i(ReadData1),
        .mem_wr_i (mem_regwrite_q),
        .mem_rd_i (mem_rd_q),
        .mem_val_i(mem_value_d),
        .wb_wr_i  (wb_regwrite_q),
        .wb_rd_i  (wb_rd_q),
        .wb_val_i (wb_value_q),
        .operand_o(Operand1)
    );

    fwd_select #(
        .DATA_LENGTH(DATA_LENGTH),
        .ADDRESS    (ADDRESS)
    ) u_fwd_rm (
        .src_i    (IdRm),
        .rf_data_i(ReadData2),
        .mem_wr_i (mem_regwrite_q),
        .mem_rd_i (mem_rd_q),
        .mem_val_i(mem_value_d),
        .wb_wr_i  (wb_regwrite_q),
        .wb_rd_i  (wb_rd_q),
        .wb_val_i (wb_value_q),
        .operand_o(Operand2)
    );

endmodule

// File: doc/writeback_forward.md
WRITEBACK_FORWARD -- requirements
Module: writeback_forward

Interface
REQ-001 Parameter DATA_LENGTH, default 64, SHALL set the data word width.
REQ-002 Parameter ADDRESS, default 5, SHALL set the register address width.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, SHALL be the synchronous, active-high reset.
REQ-005 Ports ExRegWrite / ExMemRead / ExRd, input, 1/1/5, SHALL describe the instruction in EX: writes a register, is a load, destination.
REQ-006 Port ExResult, input, 64, SHALL be the EX-stage ALU result.
REQ-007 Port MemData, input, 64, SHALL be load data, valid in the cycle a load occupies MEM.
REQ-008 Ports IdRn / IdRm, input, 5, SHALL be the ID-stage source registers, also driven to the regfile read addresses.
REQ-009 Ports ReadData1 / ReadData2, input, 64, SHALL be the regfile read data for IdRn / IdRm.
REQ-010 Ports Operand1 / Operand2, output, 64, SHALL be the hazard-corrected ID operands.
REQ-011 Port Stall, output, 1, SHALL request an IF/ID freeze plus an EX bubble.
REQ-012 Ports WriteRegister / WriteData / RegWrite, output, 5/64/1, SHALL drive the regfile write port.

Function
REQ-013 The block SHALL hold two pipeline registers: EX->MEM {RegWrite, MemRead, Rd, Result} and MEM->WB {RegWrite, Rd, Value}.
REQ-014 On each edge, EX->MEM SHALL load the EX inputs, and MEM->WB SHALL load Value = MemRead ? MemData : Result.
REQ-015 RegWrite/WriteRegister/WriteData SHALL be driven directly from the MEM->WB register, so write latency is exactly 2 cycles from EX.
REQ-016 MEM candidate value SHALL be MemRead ? MemData : Result from the EX->MEM register.
REQ-017 The MEM candidate SHALL be used for an operand when MEM.RegWrite=1, MEM.Rd==source, and source!=31.
REQ-018 If REQ-017 does not hold, the WB candidate SHALL be used for an operand when WB.RegWrite=1, WB.Rd==source, and source!=31.
REQ-019 Priority SHALL be MEM over WB over ReadData.
REQ-020 The WB candidate is forwarded because the regfile has no internal write-to-read bypass.
REQ-021 A source equal to 31 SHALL yield an operand of 0, regardless of ReadData and of any pending writes.
REQ-022 Stall SHALL be combinational and equal 1 iff ExRegWrite & ExMemRead & ExRd!=31 & (ExRd==IdRn | ExRd==IdRm).
REQ-023 During Stall, EX inputs are driven as a bubble by the caller; the block SHALL NOT gate them internally.
REQ-024 Simultaneous MEM and WB matches to the same source SHALL select MEM.
REQ-025 Back-to-back writes to the same Rd SHALL each reach the regfile in order, one per cycle.

Reset
REQ-026 While reset=1 at an edge, both pipeline registers SHALL clear to RegWrite=0, MemRead=0, Rd=31, data=0.
REQ-027 In the cycle after reset, outputs SHALL be RegWrite=0, WriteRegister=31, WriteData=0, and Stall determined only by the current inputs.
REQ-028 A reset asserted mid-stream SHALL discard in-flight writes: no RegWrite pulse for instructions already in MEM or WB.
REQ-029 After reset, Operand1 and Operand2 SHALL equal ReadData1 and ReadData2 (or 0 for source 31).

Structure
REQ-030 A shared package SHALL hold DATA_LENGTH, ADDRESS, the constant XZR=31, and an enum fwd_sel_t {FWD_RF, FWD_MEM, FWD_WB}.
REQ-031 One sub-module, fwd_select, SHALL perform the per-operand compare and 3:1 select.
REQ-032 fwd_select SHALL be instantiated twice, once for Rn and once for Rm.
REQ-033 The pipeline registers and Stall logic SHALL reside in writeback_forward.

Verification
REQ-034 Bench: EX ALU write X5=0x1234 then ID IdRn=5 next cycle -> Operand1=0x1234 (MEM forward); one cycle later with IdRn=5 -> Operand1=0x1234 (WB forward).
REQ-035 Bench: load X7 in EX with IdRm=7 -> Stall=1 that cycle; next cycle (load in MEM, MemData=0xA0) -> Stall=0, Operand2=0xA0.
REQ-036 Bench: ExRd=31, ExRegWrite=1, ExResult=0xFF, IdRn=31 -> Stall=0; Operand1=0 in all three cycles.
REQ-037 Bench: X3=0x11 then X3=0x22 on consecutive cycles, IdRn=3 -> Operand1=0x22 (MEM wins); RegWrite pulses X3=0x11 then X3=0x22.
REQ-038 Bench: reset asserted with writes in MEM and WB -> next cycle RegWrite=0, WriteRegister=31, WriteData=0; Operand1=ReadData1.
REQ-039 Bench: no hazards with ReadData1=0xDEAD, IdRn=4 -> Operand1=0xDEAD.
